serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial N-bit adder controller that time-shares a single 1-bit full-adder cell (`fullAdder1b`) across all operand bits. On a `start` request it latches the operands, feeds one bit pair per clock through the full adder LSB-first, and holds the carry in a flip-flop between bits. It shifts the sum bits into a result register and reports completion with a one-cycle `done` pulse. It is the sequencing layer above the 1-bit full adder in the arithmetic datapath, trading N cycles of latency for one adder cell.

## Interface
- `N`, default 8: operand and result width; legal range 2..32.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only in IDLE or DONE.
- `A`  in  N  operand A; sampled on the accepting edge only.
- `B`  in  N  operand B; sampled on the accepting edge only.
- `Cin`  in  1  carry-in; sampled on the accepting edge only.
- `sub`  in  1  subtract select; present only when `SERIAL_ADDER_SUB_EN` is defined.
- `busy`  out  1  high while bits are being processed (RUN).
- `done`  out  1  one-cycle completion pulse.
- `S`  out  N  sum result; held stable outside RUN.
- `Cout`  out  1  final carry-out; held stable outside RUN.

## Operation
- States: IDLE, RUN, DONE; 2-bit state register plus a bit counter of width clog2(N).
- IDLE:
  - `start=1` → load shift registers `a_sr<=A` and `b_sr<=B`.
  - Set `carry<=Cin` and `cnt<=0`, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, per cycle:
  - Full-adder inputs are `a_sr[0]`, `b_sr[0]`, `carry`.
  - Sum bit shifts into the MSB of `s_sr`; `s_sr` shifts right.
  - `carry<=` full-adder Cout; `a_sr` and `b_sr` shift right by 1; `cnt<=cnt+1`.
  - After N RUN cycles (`cnt==N-1` at the edge), go to DONE.
- DONE:
  - Lasts exactly one cycle.
  - `start=1` is accepted exactly as in IDLE and goes straight to RUN.
  - Otherwise go to IDLE.
- Outputs:
  - `S = s_sr`; `Cout = carry`.
  - Both are valid from the DONE cycle and hold until the next accepted start.
  - They change during RUN and must not be consumed then.
- `busy = (state==RUN)`; `done = (state==DONE)`.
- `start` during RUN is ignored and not queued.
- Result equals `{Cout,S} = A + B + Cin` modulo 2^(N+1).

## Timing
- Reset values:
  - state=IDLE, `busy=0`, `done=0`.
  - `S=0`, `Cout=0`, `cnt=0`, `carry=0`, shift registers cleared.
- Reset dominates `start` on the same edge.
- Reset mid-RUN aborts the operation immediately and gives reset values on the next cycle; no `done` is produced.
- Latency:
  - `start` accepted at edge 0.
  - `busy` is high for cycles 1..N.
  - `done` is high in cycle N+1, and `S`/`Cout` are valid in that cycle.
- Throughput: back-to-back operations with `start` held high in DONE give one result every N+1 cycles.
- Operands may change freely after the accepting edge; they are not re-sampled.

## Configuration
- Macro: `SERIAL_ADDER_SUB_EN`.
- Defined:
  - Adds the `sub` port, sampled on the accepting edge.
  - `sub=1` loads `b_sr<=~B`, forces `carry<=1` and ignores `Cin`.
  - Result: `S = A - B` mod 2^N; `Cout=1` means no borrow (A ≥ B unsigned).
  - `sub=0` behaves as plain add.
- Undefined: no `sub` port; adder only; the RTL contains no inversion logic.

## Test plan
- N=8, A=0x5A, B=0x3C, Cin=0, one start pulse → `busy` high 8 cycles, then `done` pulse with S=0x96, Cout=0; outputs held afterwards.
- A=0xFF, B=0x01, Cin=0 → S=0x00, Cout=1. A=0xFF, B=0xFF, Cin=1 → S=0xFF, Cout=1.
- `start` re-pulsed with A=0x01, B=0x01 during cycle 3 of RUN of 0x5A+0x3C → ignored; result still S=0x96; `done` at cycle 9 only.
- `reset` asserted at cycle 4 of RUN → next cycle `busy=0`, `done=0`, S=0x00, Cout=0; no `done` follows.
- `start` held high continuously with constant operands 0x10+0x20 → `done` every 9 cycles, S=0x30 each time.
- With `SERIAL_ADDER_SUB_EN`:
  - sub=1, A=0x10, B=0x01 → S=0x0F, Cout=1.
  - sub=1, A=0x01, B=0x02 → S=0xFF, Cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder controller that time-shares one 1-bit full adder, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the `sub` port (two's-complement subtract).

module fullAdder1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         Cout
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_a_sr;
  logic [N-1:0]   r_b_sr;
  logic [N-1:0]   r_s_sr;
  logic           r_carry;

  logic           w_accept;
  logic           w_last;
  logic           w_sum;
  logic           w_cout;
  logic [N-1:0]   w_b_load;
  logic           w_c_load;

  fullAdder1b u_fa (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout)
  );

  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_cnt == CW'(N - 1));

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as A + ~B + 1; Cout=1 then means no borrow.
  assign w_b_load = sub ? ~B : B;
  assign w_c_load = sub ? 1'b1 : Cin;
`else
  assign w_b_load = B;
  assign w_c_load = Cin;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a_sr  <= A;
        r_b_sr  <= w_b_load;
        r_carry <= w_c_load;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a_sr  <= r_a_sr >> 1;
        r_b_sr  <= r_b_sr >> 1;
        r_s_sr  <= {w_sum, r_s_sr[N-1:1]};
        r_carry <= w_cout;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign S    = r_s_sr;
  assign Cout = r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (N=8).
// Subtract vectors are exercised only when SERIAL_ADDER_SUB_EN is defined.

module tb_serial_adder_ctrl;

  localparam int unsigned N = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] S;
  logic         Cout;

  int unsigned total = 0;
  int unsigned bad   = 0;

  serial_adder_ctrl #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch one op, count busy cycles until done (bounded), then check result and hold.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sb,
                        input logic [7:0] exp_s, input logic exp_c);
    int unsigned busy_cnt;
    int unsigned guard;
    A = a; B = b; Cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
    sub = sb;
`else
    if (sb) $display("note: subtract vector %s skipped", tag);
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    A = ~a; B = ~b; Cin = ~cin;
    busy_cnt = 0;
    guard = 0;
    while (!done && guard < 20) begin
      if (busy) busy_cnt++;
      tick();
      guard++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_busy_cycles"}, busy_cnt, N);
    check({tag, "_S"}, 32'(S), 32'(exp_s));
    check({tag, "_Cout"}, 32'(Cout), 32'(exp_c));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    tick();
    check({tag, "_S_hold"}, 32'(S), 32'(exp_s));
    check({tag, "_Cout_hold"}, 32'(Cout), 32'(exp_c));
  endtask

  initial begin
    int unsigned cyc;
    int unsigned done_cyc;
    int unsigned done_cnt;
    int unsigned last_done;
    logic        saw_done;

    reset = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    start = 1'b1;
    A = 8'hAA; B = 8'h55;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_S", 32'(S), 32'd0);
    check("rst_Cout", 32'(Cout), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    run_op("add_00_00", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
    run_op("sub0_as_add", 8'h10, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0);
`endif

    // start re-pulsed during RUN cycle 3 must be ignored
    A = 8'h5A; B = 8'h3C; Cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    done_cyc = 0;
    while (cyc < 20 && done_cyc == 0) begin
      if (cyc == 3) begin
        start = 1'b1; A = 8'h01; B = 8'h01;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
      if (done) done_cyc = cyc;
    end
    start = 1'b0;
    check("ign_done_cycle", done_cyc, 32'd9);
    check("ign_S", 32'(S), 32'h96);
    tick();
    check("ign_no_rerun", 32'(busy), 32'd0);

    // reset at RUN cycle 4 aborts
    A = 8'h5A; B = 8'h3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_S", 32'(S), 32'd0);
    check("abort_Cout", 32'(Cout), 32'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_quiet", 32'(saw_done), 32'd0);

    // start held high: one result every N+1 cycles
    A = 8'h10; B = 8'h20; Cin = 1'b0;
    start = 1'b1;
    tick();
    cyc = 1;
    done_cnt = 0;
    last_done = 0;
    while (done_cnt < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (done) begin
        done_cnt++;
        check("b2b_S", 32'(S), 32'h30);
        if (done_cnt == 1) check("b2b_first", cyc, 32'd9);
        else check("b2b_period", cyc - last_done, 32'd9);
        last_done = cyc;
      end
    end
    start = 1'b0;
    check("b2b_count", done_cnt, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
